simcomp_loader: RTL and testbench

- Byte-serial program loader that sits directly upstream of the simple computer core.
- Receives a framed image over a valid/ready byte stream, assembles big-endian 16-bit words and writes them into the core's 64-word memory through a write port.
- Checks a checksum, then releases the core with `cpu_run` and a start PC.
- Until a frame is accepted, the core stays halted.

---
 rtl/simcomp_pkg.sv | 20 ++
 rtl/simcomp_loader.sv | 135 +++++++++++++
 tb/tb_simcomp_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/simcomp_pkg.sv
// Definitions shared between the program loader and the simple computer core.
package simcomp_pkg;

  localparam int          ADDR_W_DEFAULT    = 12;
  localparam int          MEM_DEPTH_DEFAULT = 64;
  localparam logic [7:0]  HEADER_DEFAULT    = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/simcomp_loader.sv
// Byte-serial framed image loader: writes 16-bit words into core memory,
// verifies an XOR checksum, then releases the core at the frame's start address.
module simcomp_loader
  import simcomp_pkg::*;
#(
  parameter int         ADDR_W    = simcomp_pkg::ADDR_W_DEFAULT,
  parameter int         MEM_DEPTH = simcomp_pkg::MEM_DEPTH_DEFAULT,
  parameter logic [7:0] HEADER    = simcomp_pkg::HEADER_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] start_pc,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, state_n;
  logic              ready_q;
  logic              xfer;
  logic [7:0]        addr_hi_b, hi_b, remaining, chk;
  logic [ADDR_W-1:0] base, waddr;
  logic [15:0]       addr16;
  logic [ADDR_W:0]   span;
  logic              fire_write, set_done, set_err;

  assign in_ready = ready_q && (state != S_DONE);
  assign xfer     = in_valid && in_ready;
  assign addr16   = {addr_hi_b, in_data};
  // Range check is evaluated one bit wider than the address so it cannot wrap.
  assign span     = {1'b0, base} + (ADDR_W+1)'(in_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fire_write = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE:    if (xfer && in_data == HEADER) state_n = S_ADDR_HI;
      S_ADDR_HI: if (xfer) state_n = S_ADDR_LO;
      S_ADDR_LO: if (xfer) state_n = S_COUNT;
      S_COUNT:
        if (xfer) begin
          if (span > DEPTH_LIM) begin
            state_n = S_ERROR;
            set_err = 1'b1;
          end else if (in_data == 8'd0) begin
            state_n = S_CHECK;
          end else begin
            state_n = S_DATA_HI;
          end
        end
      S_DATA_HI: if (xfer) state_n = S_DATA_LO;
      S_DATA_LO:
        if (xfer) begin
          fire_write = 1'b1;
          state_n    = (remaining == 8'd1) ? S_CHECK : S_DATA_HI;
        end
      S_CHECK:
        if (xfer) begin
          if (in_data == chk) begin
            state_n  = S_DONE;
            set_done = 1'b1;
          end else begin
            state_n  = S_ERROR;
            set_err  = 1'b1;
          end
        end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      addr_hi_b <= '0;
      hi_b      <= '0;
      remaining <= '0;
      chk       <= '0;
      base      <= '0;
      waddr     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      start_pc  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      mem_we  <= fire_write;
      if (xfer) begin
        case (state)
          S_IDLE:    chk <= '0;
          S_ADDR_HI: begin addr_hi_b <= in_data; chk <= chk ^ in_data; end
          S_ADDR_LO: begin
            base  <= addr16[ADDR_W-1:0];
            waddr <= addr16[ADDR_W-1:0];
            chk   <= chk ^ in_data;
          end
          S_COUNT:   begin remaining <= in_data; chk <= chk ^ in_data; end
          S_DATA_HI: begin hi_b <= in_data; chk <= chk ^ in_data; end
          S_DATA_LO: begin
            mem_addr  <= waddr;
            mem_wdata <= {hi_b, in_data};
            waddr     <= waddr + 1'b1;
            remaining <= remaining - 8'd1;
            chk       <= chk ^ in_data;
          end
          default: ;
        endcase
      end
      if (set_done) begin
        done     <= 1'b1;
        cpu_run  <= 1'b1;
        start_pc <= base;
      end
      if (set_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simcomp_loader.sv
// Directed bench for simcomp_loader: frame-level reference model plus a
// per-cycle write monitor, with literal expectations for the nominal frames.
module tb_simcomp_loader;
  import simcomp_pkg::*;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, cpu_run, done, error;
  logic [AW-1:0] mem_addr, start_pc;
  logic [15:0]   mem_wdata;

  simcomp_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .start_pc(start_pc),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; int data; } wr_t;

  int        tests = 0, fails = 0;
  logic [7:0] bytes_q[$];
  wr_t       exp_q[$];
  wr_t       act_q[$];
  int        m_done, m_err, m_pc;
  logic      prev_we = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: interpret the whole byte list as the loader should.
  task automatic model();
    int i, n, addr, cnt, x;
    exp_q.delete();
    m_done = 0; m_err = 0; m_pc = 0;
    n = bytes_q.size();
    i = 0;
    while (i < n && bytes_q[i] != HEADER_DEFAULT) i++;
    if (i + 3 >= n) return;
    addr = ({bytes_q[i+1], bytes_q[i+2]}) & ((1 << AW) - 1);
    cnt  = bytes_q[i+3];
    if (addr + cnt > MEM_DEPTH_DEFAULT) begin m_err = 1; return; end
    x = bytes_q[i+1] ^ bytes_q[i+2] ^ bytes_q[i+3];
    for (int w = 0; w < cnt; w++) begin
      if (i + 5 + 2*w < n) begin
        exp_q.push_back('{addr + w, {bytes_q[i+4+2*w], bytes_q[i+5+2*w]}});
        x = x ^ bytes_q[i+4+2*w] ^ bytes_q[i+5+2*w];
      end
    end
    if (i + 4 + 2*cnt < n) begin
      if (bytes_q[i+4+2*cnt] == x[7:0]) begin m_done = 1; m_pc = addr; end
      else m_err = 1;
    end
  endtask

  // Write monitor: every strobe must match the next modelled write.
  always @(negedge clock) begin
    if (mem_we) begin
      act_q.push_back('{int'(mem_addr), int'(mem_wdata)});
      if (exp_q.size() == 0) check("unexpected_write", int'(mem_addr), -1);
      else begin
        check("wr_addr", int'(mem_addr), exp_q[0].addr);
        check("wr_data", int'(mem_wdata), exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (prev_we) check("we_single_cycle", 1, 0);
    end
    prev_we = mem_we;
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    act_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input int max_gap);
    logic acc;
    if (max_gap > 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(posedge clock);
      #1;
    end
    in_data = b; in_valid = 1'b1; acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      acc = in_ready;
      @(posedge clock); #1;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int max_gap);
    model();
    foreach (bytes_q[i]) begin
      if (max_gap > 0 && i == 6) begin
        repeat (12) @(posedge clock);
        #1;
      end
      send(bytes_q[i], max_gap);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_final(input string tag);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_done"}, int'(done), m_done);
    check({tag, "_error"}, int'(error), m_err);
    check({tag, "_cpu_run"}, int'(cpu_run), m_done);
    check({tag, "_start_pc"}, int'(start_pc), m_pc);
    check({tag, "_in_ready"}, int'(in_ready), m_done ? 0 : 1);
  endtask

  task automatic load_nominal(input logic [7:0] chk_b);
    bytes_q = '{8'hA5, 8'h00, 8'h0A, 8'h03, 8'h30, 8'h20, 8'h70, 8'h21,
                8'hB0, 8'h14, chk_b};
  endtask

  initial begin
    // Reset values while reset is held
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_outputs", int'({mem_we, cpu_run, done, error}), 0);
    check("rst_addr_data_pc", int'(mem_addr | start_pc | mem_wdata), 0);
    do_reset();
    check("ready_after_reset", int'(in_ready), 1);

    // Nominal load
    load_nominal(8'hEC);
    run_frame(0);
    check_final("nominal");
    check("nom_nwrites", act_q.size(), 3);
    if (act_q.size() == 3) begin
      check("nom_w0_addr", act_q[0].addr, 10);
      check("nom_w0_data", act_q[0].data, 16'h3020);
      check("nom_w1_data", act_q[1].data, 16'h7021);
      check("nom_w2_addr", act_q[2].addr, 12);
      check("nom_w2_data", act_q[2].data, 16'hB014);
    end
    check("nom_done_lit", int'(done), 1);
    check("nom_pc_lit", int'(start_pc), 10);

    // Bad checksum
    do_reset();
    load_nominal(8'hED);
    run_frame(0);
    check_final("badchk");
    check("badchk_nwrites", act_q.size(), 3);
    check("badchk_error_lit", int'(error), 1);
    check("badchk_run_lit", int'(cpu_run), 0);
    check("badchk_ready_lit", int'(in_ready), 1);

    // Range overflow: error right after COUNT, trailing bytes drained
    do_reset();
    bytes_q = '{8'hA5, 8'h00, 8'h3E, 8'h03};
    model();
    foreach (bytes_q[i]) send(bytes_q[i], 0);
    check("ovf_error_lit", int'(error), 1);
    bytes_q = '{8'hA5, 8'h00, 8'h3E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    model();
    for (int i = 4; i < 8; i++) send(bytes_q[i], 0);
    repeat (3) @(posedge clock);
    #1;
    check_final("overflow");
    check("ovf_nwrites", act_q.size(), 0);

    // Zero count with leading noise
    do_reset();
    bytes_q = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h05, 8'h00, 8'h05};
    run_frame(0);
    check_final("zero");
    check("zero_nwrites", act_q.size(), 0);
    check("zero_pc_lit", int'(start_pc), 5);

    // Stalls
    do_reset();
    load_nominal(8'hEC);
    run_frame(4);
    check_final("stall");
    check("stall_nwrites", act_q.size(), 3);
    check("stall_pc_lit", int'(start_pc), 10);

    // Mid-frame reset after the 5th byte
    do_reset();
    load_nominal(8'hEC);
    for (int i = 0; i < 5; i++) send(bytes_q[i], 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", int'(in_ready), 0);
    check("midrst_outputs", int'({mem_we, cpu_run, done, error}), 0);
    check("midrst_addr_data_pc", int'(mem_addr | start_pc | mem_wdata), 0);
    exp_q.delete();
    do_reset();
    load_nominal(8'hEC);
    run_frame(0);
    check_final("after_rst");
    check("after_rst_nwrites", act_q.size(), 3);
    check("after_rst_pc_lit", int'(start_pc), 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
